// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between core store port and data memory,
// with youngest-match load forwarding and saturating accepted-store counter.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  output logic          stall,
  output logic          ld_hit,
  output logic [DW-1:0] ld_data,
  output logic          mem_valid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  output logic          empty,
  output logic [CW-1:0] store_count
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, idx;
  logic [PW:0]   count_q, count_d;
  logic [CW-1:0] store_count_q, store_count_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic          full, enq, deq;
  assign full        = count_q == (PW+1)'(DEPTH);
  assign empty       = count_q == '0;
  assign stall       = memwrite & full;
  assign enq         = memwrite & ~full;
  assign mem_valid   = ~empty;
  assign deq         = mem_valid & mem_ready;
  assign mem_addr    = addr_q[rd_ptr_q];
  assign mem_wdata   = data_q[rd_ptr_q];
  assign store_count = store_count_q;
  always_comb begin
    rd_ptr_d      = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d      = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d       = count_q + (PW+1)'(enq) - (PW+1)'(deq);
    store_count_d = (enq && store_count_q != '1) ? store_count_q + 1'b1 : store_count_q;
  end
  // Scan oldest to youngest so the last hit (youngest) wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((PW+1)'(i) < count_q && addr_q[idx] == dataadr) begin
        ld_hit  = 1'b1;
        ld_data = data_q[idx];
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      store_count_q <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      store_count_q <= store_count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr_q] <= dataadr;
      data_q[wr_ptr_q] <= writedata;
    end
  end
endmodule
